keypad_entry_assembler: RTL and testbench



---
 rtl/keypad_entry_assembler_if.sv | 41 ++++
 rtl/keypad_entry_assembler.sv | 93 +++++++++
 tb/tb_keypad_entry_assembler.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_assembler_if.sv
// Handshake bundle between the keypad FIFO, the entry assembler and its consumer.
// The master side is the environment (FIFO plus consumer); the slave side is the assembler.
interface keypad_entry_assembler_if #(
    parameter int num_digits = 4
);
    localparam int W = 4 * num_digits;

    logic         empty;
    logic [3:0]   fifo_data;
    logic         read;
    logic [W-1:0] buffer;
    logic [3:0]   digit_count;
    logic         overrun;
    logic [W-1:0] entry_value;
    logic         entry_valid;
    logic         entry_ack;

    modport master (
        output empty,
        output fifo_data,
        output entry_ack,
        input  read,
        input  buffer,
        input  digit_count,
        input  overrun,
        input  entry_value,
        input  entry_valid
    );

    modport slave (
        input  empty,
        input  fifo_data,
        input  entry_ack,
        output read,
        output buffer,
        output digit_count,
        output overrun,
        output entry_value,
        output entry_valid
    );
endinterface

// File: rtl/keypad_entry_assembler.sv
// Pops key codes from the keypad FIFO and assembles hex digits into an entry.
// ENTER commits the buffer to a valid/ack output; CLEAR empties it.
module keypad_entry_assembler #(
    parameter int         num_digits = 4,
    parameter logic [3:0] enter_code = 4'hF,
    parameter logic [3:0] clear_code = 4'hC
) (
    input  logic                     clock,
    input  logic                     reset,
    keypad_entry_assembler_if.slave  bus
);
    localparam int W = 4 * num_digits;
    localparam logic [3:0] MAX_CNT = 4'(num_digits);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2
    } state_t;

    state_t       r_state;
    logic         r_read;
    logic [W-1:0] r_buffer;
    logic [3:0]   r_digit_count;
    logic         r_overrun;
    logic [W-1:0] r_entry_value;
    logic         r_entry_valid;

    logic [W-1:0] w_shift;

    // Drop the oldest digit; works for a single-digit buffer too.
    assign w_shift = W'({r_buffer, bus.fifo_data});

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_read        <= 1'b0;
            r_buffer      <= '0;
            r_digit_count <= '0;
            r_overrun     <= 1'b0;
            r_entry_value <= '0;
            r_entry_valid <= 1'b0;
        end else begin
            if (bus.entry_ack && r_entry_valid)
                r_entry_valid <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (!bus.empty && !r_entry_valid) begin
                        r_state <= RD;
                        r_read  <= 1'b1;
                    end
                end
                RD: begin
                    r_state <= CAP;
                    r_read  <= 1'b0;
                end
                CAP: begin
                    r_state <= IDLE;
                    if (bus.fifo_data == clear_code) begin
                        r_buffer      <= '0;
                        r_digit_count <= '0;
                        r_overrun     <= 1'b0;
                    end else if (bus.fifo_data == enter_code) begin
                        if (r_digit_count != 4'd0) begin
                            r_entry_value <= r_buffer;
                            r_entry_valid <= 1'b1;
                            r_buffer      <= '0;
                            r_digit_count <= '0;
                            r_overrun     <= 1'b0;
                        end
                    end else if (r_digit_count < MAX_CNT) begin
                        r_buffer      <= w_shift;
                        r_digit_count <= r_digit_count + 4'd1;
                    end else begin
                        r_overrun <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_read  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.read        = r_read;
    assign bus.buffer      = r_buffer;
    assign bus.digit_count = r_digit_count;
    assign bus.overrun     = r_overrun;
    assign bus.entry_value = r_entry_value;
    assign bus.entry_valid = r_entry_valid;
endmodule

// File: tb/tb_keypad_entry_assembler.sv
// Directed bench for keypad_entry_assembler with a FIFO model and
// a scoreboard of expected committed entries.
module tb_keypad_entry_assembler;
    logic clock;
    logic reset;

    keypad_entry_assembler_if #(.num_digits(4)) bus ();

    keypad_entry_assembler #(
        .num_digits(4),
        .enter_code(4'hF),
        .clear_code(4'hC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_reads = 0;

    logic [3:0]  fifo_q [$];
    logic [15:0] sb_q   [$];
    int          rd_q   [$];
    logic        prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO model: word appears on fifo_data the cycle after the read pulse.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bus.read && fifo_q.size() > 0)
            bus.fifo_data <= fifo_q.pop_front();
    end

    always @(negedge clock)
        bus.empty <= (fifo_q.size() == 0);

    // Monitor: scoreboard pops on each commit, read log, no read while valid.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.entry_valid && !prev_valid) begin
                if (sb_q.size() == 0)
                    check("unexpected_commit", {16'h0, bus.entry_value}, 32'hDEAD);
                else
                    check("sb_entry_value", {16'h0, bus.entry_value},
                          {16'h0, sb_q.pop_front()});
            end
            if (bus.read) begin
                n_reads++;
                rd_q.push_back(cyc);
                check("read_while_valid", {31'h0, bus.entry_valid}, 32'h0);
            end
        end
        prev_valid <= bus.entry_valid;
    end

    task automatic push_key(input logic [3:0] k);
        @(negedge clock);
        #1;
        fifo_q.push_back(k);
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_ack();
        @(negedge clock);
        bus.entry_ack = 1'b1;
        @(negedge clock);
        bus.entry_ack = 1'b0;
    endtask

    int rd_before;

    initial begin
        reset = 1'b1;
        bus.entry_ack = 1'b0;
        bus.fifo_data = 4'h0;
        bus.empty = 1'b1;
        run(3);
        reset = 1'b0;
        run(1);
        check("rst_read",        {31'h0, bus.read},        32'h0);
        check("rst_buffer",      {16'h0, bus.buffer},      32'h0);
        check("rst_count",       {28'h0, bus.digit_count}, 32'h0);
        check("rst_overrun",     {31'h0, bus.overrun},     32'h0);
        check("rst_entry_value", {16'h0, bus.entry_value}, 32'h0);
        check("rst_entry_valid", {31'h0, bus.entry_valid}, 32'h0);

        // Reset lands on the CAP cycle: the popped key is lost.
        push_key(4'h7);
        for (int i = 0; i < 20 && !bus.read; i++) @(negedge clock);
        check("midpop_read_seen", {31'h0, bus.read}, 32'h1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midpop_buffer",  {16'h0, bus.buffer},      32'h0);
        check("midpop_count",   {28'h0, bus.digit_count}, 32'h0);
        check("midpop_read",    {31'h0, bus.read},        32'h0);
        check("midpop_fifo",    fifo_q.size(),            32'h0);
        run(6);
        check("midpop_after",   {16'h0, bus.buffer},      32'h0);

        // Digit entry, reads three cycles apart.
        rd_q.delete();
        @(negedge clock);
        #1;
        fifo_q.push_back(4'h1);
        fifo_q.push_back(4'h2);
        fifo_q.push_back(4'h3);
        run(14);
        check("digits_buffer",  {16'h0, bus.buffer},      32'h0123);
        check("digits_count",   {28'h0, bus.digit_count}, 32'd3);
        check("digits_overrun", {31'h0, bus.overrun},     32'h0);
        check("digits_nreads",  rd_q.size(),              32'd3);
        if (rd_q.size() == 3) begin
            check("digits_gap1", rd_q[1] - rd_q[0], 32'd3);
            check("digits_gap2", rd_q[2] - rd_q[1], 32'd3);
        end

        // Commit with backpressure; key 5 must stay queued.
        @(negedge clock);
        #1;
        fifo_q.push_back(4'hC);
        fifo_q.push_back(4'h1);
        fifo_q.push_back(4'h2);
        fifo_q.push_back(4'h3);
        fifo_q.push_back(4'h4);
        fifo_q.push_back(4'hF);
        fifo_q.push_back(4'h5);
        sb_q.push_back(16'h1234);
        run(40);
        check("commit_valid",  {31'h0, bus.entry_valid},  32'h1);
        check("commit_value",  {16'h0, bus.entry_value},  32'h1234);
        check("commit_buffer", {16'h0, bus.buffer},       32'h0);
        check("commit_count",  {28'h0, bus.digit_count},  32'h0);
        check("commit_fifo5",  fifo_q.size(),             32'd1);
        pulse_ack();
        check("ack_valid",     {31'h0, bus.entry_valid},  32'h0);
        check("ack_hold",      {16'h0, bus.entry_value},  32'h1234);
        run(8);
        check("post_buffer",   {16'h0, bus.buffer},       32'h0005);
        check("post_count",    {28'h0, bus.digit_count},  32'd1);
        check("post_fifo",     fifo_q.size(),             32'd0);

        // Overrun on the fifth digit, then CLEAR.
        @(negedge clock);
        #1;
        fifo_q.push_back(4'hC);
        fifo_q.push_back(4'hA);
        fifo_q.push_back(4'hB);
        fifo_q.push_back(4'hD);
        fifo_q.push_back(4'hE);
        fifo_q.push_back(4'h9);
        run(24);
        check("ovr_buffer",  {16'h0, bus.buffer},      32'hABDE);
        check("ovr_count",   {28'h0, bus.digit_count}, 32'd4);
        check("ovr_flag",    {31'h0, bus.overrun},     32'h1);
        push_key(4'hC);
        run(8);
        check("clr_buffer",  {16'h0, bus.buffer},      32'h0);
        check("clr_count",   {28'h0, bus.digit_count}, 32'h0);
        check("clr_overrun", {31'h0, bus.overrun},     32'h0);

        // ENTER on an empty buffer, then a spurious ack.
        push_key(4'hF);
        run(8);
        check("emptyent_valid", {31'h0, bus.entry_valid}, 32'h0);
        check("emptyent_value", {16'h0, bus.entry_value}, 32'h1234);
        pulse_ack();
        check("spur_valid",  {31'h0, bus.entry_valid}, 32'h0);
        check("spur_value",  {16'h0, bus.entry_value}, 32'h1234);
        check("spur_buffer", {16'h0, bus.buffer},      32'h0);

        // Empty FIFO for 100 cycles: no reads, outputs hold.
        push_key(4'h8);
        run(8);
        rd_before = n_reads;
        run(100);
        check("idle_reads",  n_reads - rd_before,     32'd0);
        check("idle_buffer", {16'h0, bus.buffer},      32'h0008);
        check("idle_count",  {28'h0, bus.digit_count}, 32'd1);
        check("idle_valid",  {31'h0, bus.entry_valid}, 32'h0);
        check("sb_drained",  sb_q.size(),              32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
